// File: rtl/vga_fb_fetch.sv
// Framebuffer fetch scheduler: Wishbone burst reads of 16-bit pixels
// into a pixel FIFO ahead of the VGA scan, head presented to the pixel stage.
module vga_fb_fetch #(
   parameter int          HDISP      = 640,
   parameter int          VDISP      = 480,
   parameter int          BURST      = 16,
   parameter int          FIFO_DEPTH = 256,
   parameter logic [31:0] BASE_ADDR  = 32'h0
) (
   input  logic        VGA_CLK,
   input  logic        RST,
   input  logic        frame_start,
   input  logic        pix_rd,
   output logic [15:0] pix_data,
   output logic        pix_valid,
   output logic        underflow,
   output logic        busy,
   output logic [31:0] wb_adr,
   output logic        wb_cyc,
   output logic        wb_stb,
   output logic        wb_we,
   output logic [1:0]  wb_sel,
   output logic [2:0]  wb_cti,
   output logic [1:0]  wb_bte,
   input  logic [15:0] wb_dat_sm,
   input  logic        wb_ack
);

   localparam int TOTAL = HDISP * VDISP;
   localparam int RW    = $clog2(TOTAL + 1);
   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CW    = AW + 1;
   localparam int BW    = (BURST > 1) ? $clog2(BURST) : 1;

   localparam logic [CW-1:0] SPACE_LIM = CW'(FIFO_DEPTH - BURST);
   localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);
   localparam logic [RW-1:0] TOTAL_R   = RW'(TOTAL);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WAIT  = 3'd1;
   localparam logic [2:0] S_BURST = 3'd2;
   localparam logic [2:0] S_GAP   = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   generate
      if (BURST < 1 || (BURST & (BURST - 1)) != 0) begin : g_bad_burst
         $error("vga_fb_fetch: BURST must be a power of 2");
      end
      if ((TOTAL % BURST) != 0) begin : g_bad_total
         $error("vga_fb_fetch: HDISP*VDISP must be a multiple of BURST");
      end
      if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH < 2 * BURST) begin : g_bad_fifo
         $error("vga_fb_fetch: FIFO_DEPTH must be a power of 2 and >= 2*BURST");
      end
   endgenerate

   logic [2:0]    state;
   logic [RW-1:0] remaining;
   logic [BW-1:0] beat;
   logic [15:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] cnt;
   logic          push;
   logic          pop;

   assign push = (state == S_BURST) && wb_ack;
   assign pop  = pix_rd && pix_valid;

   always_ff @(posedge VGA_CLK) begin
      if (RST) begin
         state     <= S_IDLE;
         wb_adr    <= BASE_ADDR;
         remaining <= '0;
         beat      <= '0;
         underflow <= 1'b0;
      end else if (frame_start) begin
         // restart wins over any in-flight beat, so a late ack is dropped
         state     <= S_WAIT;
         wb_adr    <= BASE_ADDR;
         remaining <= TOTAL_R;
         beat      <= '0;
         underflow <= 1'b0;
      end else begin
         if (pix_rd && !pix_valid)
            underflow <= 1'b1;
         unique case (state)
            S_WAIT: begin
               if (remaining == '0)
                  state <= S_DONE;
               else if (cnt <= SPACE_LIM)
                  state <= S_BURST;
            end
            S_BURST: begin
               if (wb_ack) begin
                  wb_adr    <= wb_adr + 32'd2;
                  remaining <= remaining - RW'(1);
                  if (beat == LAST_BEAT) begin
                     beat  <= '0;
                     state <= S_GAP;
                  end else begin
                     beat <= beat + BW'(1);
                  end
               end
            end
            S_GAP:   state <= S_WAIT;
            default: state <= state;
         endcase
      end
   end

   always_ff @(posedge VGA_CLK) begin
      if (RST || frame_start) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)
            cnt <= cnt + CW'(1);
         else if (pop && !push)
            cnt <= cnt - CW'(1);
      end
   end

   always_ff @(posedge VGA_CLK) begin
      if (push && !RST && !frame_start)
         mem[wr_ptr] <= wb_dat_sm;
   end

   assign pix_valid = (cnt != '0);
   assign pix_data  = pix_valid ? mem[rd_ptr] : 16'h0000;
   assign busy      = (state != S_IDLE) && (state != S_DONE);
   assign wb_cyc    = (state == S_BURST);
   assign wb_stb    = wb_cyc;
   assign wb_cti    = !wb_cyc ? 3'b000 :
                      (beat == LAST_BEAT) ? 3'b111 : 3'b010;
   assign wb_we     = 1'b0;
   assign wb_sel    = 2'b11;
   assign wb_bte    = 2'b00;

endmodule

// File: tb/tb_vga_fb_fetch.sv
// Directed bench for vga_fb_fetch with a small Wishbone slave model;
// slave data for byte address 0x1000+2*i is 16'hA000+i.
module tb_vga_fb_fetch;

   logic        clk = 1'b0;
   logic        RST = 1'b1;
   logic        frame_start = 1'b0;
   logic        pix_rd = 1'b0;
   logic [15:0] pix_data;
   logic        pix_valid;
   logic        underflow;
   logic        busy;
   logic [31:0] wb_adr;
   logic        wb_cyc;
   logic        wb_stb;
   logic        wb_we;
   logic [1:0]  wb_sel;
   logic [2:0]  wb_cti;
   logic [1:0]  wb_bte;
   logic [15:0] wb_dat_sm;
   logic        wb_ack;

   int total = 0;
   int bad   = 0;
   int waits = 0;
   int wcnt  = 0;
   logic ack_en = 1'b1;
   logic stray  = 1'b0;

   vga_fb_fetch #(
      .HDISP(8), .VDISP(4), .BURST(4), .FIFO_DEPTH(8), .BASE_ADDR(32'h1000)
   ) dut (
      .VGA_CLK(clk), .RST(RST), .frame_start(frame_start), .pix_rd(pix_rd),
      .pix_data(pix_data), .pix_valid(pix_valid), .underflow(underflow),
      .busy(busy), .wb_adr(wb_adr), .wb_cyc(wb_cyc), .wb_stb(wb_stb),
      .wb_we(wb_we), .wb_sel(wb_sel), .wb_cti(wb_cti), .wb_bte(wb_bte),
      .wb_dat_sm(wb_dat_sm), .wb_ack(wb_ack)
   );

   always #5 clk = ~clk;

   logic [31:0] adr_off;
   assign adr_off   = (wb_adr - 32'h1000) >> 1;
   assign wb_dat_sm = 16'hA000 + adr_off[15:0];
   assign wb_ack    = (wb_stb && ack_en && (wcnt == waits)) || stray;

   always @(posedge clk) begin
      if (!wb_stb || wb_ack) wcnt <= 0;
      else wcnt <= wcnt + 1;
   end

   task automatic pulse_fs();
      @(posedge clk); #1 frame_start = 1'b1;
      @(posedge clk); #1 frame_start = 1'b0;
   endtask

   task automatic wait_cyc(input string nm);
      bit seen = 0;
      for (int i = 0; i < 60 && !seen; i++) begin
         @(negedge clk);
         if (wb_cyc) seen = 1;
      end
      total++;
      if (!seen) begin
         bad++;
         $display("FAIL %s: wb_cyc never rose, got 0 required 1", nm);
      end
   endtask

   task automatic test_reset();
      RST = 1'b1;
      repeat (3) @(posedge clk);
      #1 RST = 1'b0;
      @(negedge clk);
      total++; if (wb_cyc !== 1'b0) begin bad++; $display("FAIL rst_cyc: got %b required 0", wb_cyc); end
      total++; if (wb_adr !== 32'h1000) begin bad++; $display("FAIL rst_adr: got %h required 00001000", wb_adr); end
      total++; if (wb_cti !== 3'b000) begin bad++; $display("FAIL rst_cti: got %b required 000", wb_cti); end
      total++; if ({wb_we, wb_sel, wb_bte} !== 5'b0_11_00) begin bad++; $display("FAIL rst_fixed: got %b required 01100", {wb_we, wb_sel, wb_bte}); end
      total++; if ({pix_valid, underflow, busy} !== 3'b000) begin bad++; $display("FAIL rst_flags: got %b required 000", {pix_valid, underflow, busy}); end
      total++; if (pix_data !== 16'h0) begin bad++; $display("FAIL rst_data: got %h required 0000", pix_data); end
   endtask

   task automatic test_first_burst();
      logic [31:0] ea;
      logic [2:0]  ec;
      waits = 0; ack_en = 1'b1; pix_rd = 1'b0;
      pulse_fs();
      @(negedge clk);
      total++; if (wb_cyc !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL fb_t1: cyc/busy got %b%b required 01", wb_cyc, busy); end
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         ea = 32'h1000 + 32'(2 * i);
         ec = (i == 3) ? 3'b111 : 3'b010;
         total++; if (wb_cyc !== 1'b1 || wb_stb !== 1'b1) begin bad++; $display("FAIL fb_cyc%0d: got %b%b required 11", i, wb_cyc, wb_stb); end
         total++; if (wb_adr !== ea) begin bad++; $display("FAIL fb_adr%0d: got %h required %h", i, wb_adr, ea); end
         total++; if (wb_cti !== ec) begin bad++; $display("FAIL fb_cti%0d: got %b required %b", i, wb_cti, ec); end
         if (i == 0) begin
            total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL fb_valid_early: got %b required 0", pix_valid); end
         end
         if (i == 1) begin
            total++; if (pix_valid !== 1'b1 || pix_data !== 16'hA000) begin bad++; $display("FAIL fb_valid_t3: got %b/%h required 1/a000", pix_valid, pix_data); end
         end
      end
      @(negedge clk);
      total++; if (wb_cyc !== 1'b0) begin bad++; $display("FAIL fb_gap: got %b required 0", wb_cyc); end
      wait_cyc("fb_second");
      total++; if (wb_adr !== 32'h1008) begin bad++; $display("FAIL fb_adr2: got %h required 00001008", wb_adr); end
   endtask

   task automatic test_fill();
      int bursts = 0;
      logic pc = 1'b0;
      waits = 0; ack_en = 1'b1; pix_rd = 1'b0;
      pulse_fs();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (wb_cyc && !pc) bursts++;
         pc = wb_cyc;
      end
      total++; if (bursts !== 2) begin bad++; $display("FAIL fill_bursts: got %0d required 2", bursts); end
      total++; if ({wb_cyc, pix_valid, busy} !== 3'b011) begin bad++; $display("FAIL fill_idle: got %b required 011", {wb_cyc, pix_valid, busy}); end
      total++; if (wb_adr !== 32'h1010) begin bad++; $display("FAIL fill_adr: got %h required 00001010", wb_adr); end
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1 pix_rd = 1'b1;
         @(negedge clk);
         total++;
         if (pix_data !== 16'hA000 + 16'(i)) begin bad++; $display("FAIL fill_pop%0d: got %h required %h", i, pix_data, 16'hA000 + 16'(i)); end
      end
      @(posedge clk); #1 pix_rd = 1'b0;
      wait_cyc("fill_resume");
      total++; if (wb_adr !== 32'h1010) begin bad++; $display("FAIL fill_resume_adr: got %h required 00001010", wb_adr); end
   endtask

   task automatic run_frame(input string nm, input int w, input bit greedy, input bit exp_uf);
      int n = 0;
      int bursts = 0;
      bit done = 0;
      logic pc = 1'b0, ps = 1'b0, pa = 1'b0;
      logic [31:0] padr = '0;
      logic [2:0]  pcti = '0;
      waits = w; ack_en = 1'b1; pix_rd = greedy;
      pulse_fs();
      for (int c = 0; c < 1500 && !done; c++) begin
         @(negedge clk);
         if (pix_rd && pix_valid) begin
            total++;
            if (pix_data !== 16'hA000 + 16'(n)) begin bad++; $display("FAIL %s_pix%0d: got %h required %h", nm, n, pix_data, 16'hA000 + 16'(n)); end
            n++;
         end
         if (ps && !pa && wb_stb) begin
            total++;
            if (wb_adr !== padr || wb_cti !== pcti) begin bad++; $display("FAIL %s_hold: got %h/%b required %h/%b", nm, wb_adr, wb_cti, padr, pcti); end
         end
         if (wb_cyc && !pc) bursts++;
         pc = wb_cyc; ps = wb_stb; pa = wb_ack; padr = wb_adr; pcti = wb_cti;
         if (!busy && !pix_valid && c > 2) done = 1;
         @(posedge clk); #1;
         if (!greedy) pix_rd = pix_valid;
      end
      pix_rd = 1'b0;
      total++; if (!done) begin bad++; $display("FAIL %s_timeout: got busy=%b required 0", nm, busy); end
      total++; if (n !== 32) begin bad++; $display("FAIL %s_count: got %0d required 32", nm, n); end
      total++; if (bursts !== 8) begin bad++; $display("FAIL %s_bursts: got %0d required 8", nm, bursts); end
      @(negedge clk);
      total++; if (wb_adr !== 32'h1040) begin bad++; $display("FAIL %s_end_adr: got %h required 00001040", nm, wb_adr); end
      total++; if (wb_cyc !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL %s_end_idle: got %b%b required 00", nm, wb_cyc, busy); end
      total++; if (underflow !== exp_uf) begin bad++; $display("FAIL %s_underflow: got %b required %b", nm, underflow, exp_uf); end
   endtask

   task automatic test_abort();
      waits = 0; ack_en = 1'b1; pix_rd = 1'b0;
      pulse_fs();
      wait_cyc("ab_start");
      @(posedge clk);
      @(posedge clk); #1 frame_start = 1'b1;
      @(posedge clk); #1 frame_start = 1'b0; ack_en = 1'b0; stray = 1'b1;
      @(negedge clk);
      total++; if ({wb_cyc, pix_valid, busy} !== 3'b001) begin bad++; $display("FAIL ab_t1: got %b required 001", {wb_cyc, pix_valid, busy}); end
      total++; if (wb_adr !== 32'h1000) begin bad++; $display("FAIL ab_adr: got %h required 00001000", wb_adr); end
      @(posedge clk); #1 stray = 1'b0; ack_en = 1'b1;
      @(negedge clk);
      total++; if (wb_cyc !== 1'b1 || wb_adr !== 32'h1000) begin bad++; $display("FAIL ab_t2: got %b/%h required 1/00001000", wb_cyc, wb_adr); end
      total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL ab_stray: got %b required 0", pix_valid); end
      @(negedge clk);
      total++; if (pix_valid !== 1'b1 || pix_data !== 16'hA000) begin bad++; $display("FAIL ab_data: got %b/%h required 1/a000", pix_valid, pix_data); end
   endtask

   task automatic test_reset_mid();
      bit rose = 0;
      waits = 0; ack_en = 1'b1; pix_rd = 1'b0;
      pulse_fs();
      wait_cyc("rm_start");
      @(posedge clk); #1 RST = 1'b1;
      @(posedge clk); #1 RST = 1'b0;
      @(negedge clk);
      total++; if ({wb_cyc, pix_valid, busy, underflow} !== 4'b0000) begin bad++; $display("FAIL rm_flags: got %b required 0000", {wb_cyc, pix_valid, busy, underflow}); end
      total++; if (wb_adr !== 32'h1000 || wb_cti !== 3'b000) begin bad++; $display("FAIL rm_bus: got %h/%b required 00001000/000", wb_adr, wb_cti); end
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (wb_cyc) rose = 1;
      end
      total++; if (rose) begin bad++; $display("FAIL rm_quiet: got cyc=1 required 0"); end
      run_frame("rd", 0, 1'b1, 1'b1);
      @(posedge clk); #1 RST = 1'b1;
      @(posedge clk); #1 RST = 1'b0;
      @(negedge clk);
      total++; if ({wb_cyc, pix_valid, busy, underflow} !== 4'b0000) begin bad++; $display("FAIL rd_flags: got %b required 0000", {wb_cyc, pix_valid, busy, underflow}); end
      total++; if (wb_adr !== 32'h1000) begin bad++; $display("FAIL rd_adr: got %h required 00001000", wb_adr); end
   endtask

   initial begin
      test_reset();
      test_first_burst();
      test_fill();
      run_frame("ws", 2, 1'b0, 1'b0);
      run_frame("ff", 0, 1'b1, 1'b1);
      test_abort();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
